fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/gray_ptr_counter.sv | 31 +++
 rtl/fifo_wr_ctrl.sv | 95 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO state type and Gray/binary pointer helpers
package fifo_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } wr_state_t;

  // Helpers work on 32 bits; callers zero-extend in and truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_counter.sv
// rtl/gray_ptr_counter.sv - binary plus Gray pointer with increment enable
module gray_ptr_counter
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  always_comb begin
    bin_next  = bin + W'(inc);
    gray_next = W'(bin2gray(32'(bin_next)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side controller with memory scrub
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int AF_MARGIN = 2,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int PTR_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  input  logic [PTR_W-1:0]  rptr_gray_sync,
  output logic [PTR_W-1:0]  wptr_gray,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              full,
  output logic              almost_full
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_MARGIN < 0 || AF_MARGIN >= DEPTH) begin : g_param_err
    $error("fifo_wr_ctrl: DEPTH must be a power of two >= 2 and AF_MARGIN in [0, DEPTH)");
  end

  wr_state_t         state;
  logic [ADDR_W-1:0] init_cnt;
  logic [PTR_W-1:0]  wptr_bin;
  logic [PTR_W-1:0]  next_wbin;
  logic [PTR_W-1:0]  next_wgray;
  logic [PTR_W-1:0]  rptr_bin;
  logic [PTR_W-1:0]  fill_next;
  logic [PTR_W-1:0]  full_gray;
  logic              xfer;

  assign wr_ready = (state == S_RUN) && !full;
  assign xfer     = wr_valid && wr_ready;

  gray_ptr_counter #(.W(PTR_W)) u_wptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (xfer),
    .bin       (wptr_bin),
    .gray      (wptr_gray),
    .bin_next  (next_wbin),
    .gray_next (next_wgray)
  );

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  if (PTR_W == 2) begin : g_full_d2
    assign full_gray = ~rptr_gray_sync;
  end else begin : g_full_dn
    assign full_gray = {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]};
  end

  assign rptr_bin  = PTR_W'(gray2bin(32'(rptr_gray_sync)));
  assign fill_next = next_wbin - rptr_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      mem_wen     <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      full        <= (next_wgray == full_gray);
      almost_full <= (fill_next >= PTR_W'(DEPTH - AF_MARGIN));
      case (state)
        S_INIT: begin
          mem_wen   <= 1'b1;
          mem_waddr <= init_cnt;
          mem_wdata <= '0;
          init_cnt  <= init_cnt + ADDR_W'(1);
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          mem_wen <= xfer;
          if (xfer) begin
            mem_waddr <= wptr_bin[ADDR_W-1:0];
            mem_wdata <= wr_data;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] rptr_gray_sync;
  logic [3:0] wptr_gray;
  logic       mem_wen;
  logic [2:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       full;
  logic       almost_full;

  int checks = 0;
  int errors = 0;

  fifo_wr_ctrl #(.DEPTH(8), .WIDTH(8), .AF_MARGIN(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rptr_gray_sync (rptr_gray_sync),
    .wptr_gray      (wptr_gray),
    .mem_wen        (mem_wen),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .full           (full),
    .almost_full    (almost_full)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wen"},   32'(mem_wen),     32'd0);
    chk({tag, "_waddr"}, 32'(mem_waddr),   32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata),   32'd0);
    chk({tag, "_full"},  32'(full),        32'd0);
    chk({tag, "_af"},    32'(almost_full), 32'd0);
    chk({tag, "_wgray"}, 32'(wptr_gray),   32'd0);
    chk({tag, "_ready"}, 32'(wr_ready),    32'd0);
  endtask

  initial begin
    logic [3:0] exp_bin;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    rptr_gray_sync = 4'b0000;
    tick();
    tick();
    chk_reset("rst");

    // Scrub with wr_valid held high: it must be ignored.
    rst = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("scrub_wen",   32'(mem_wen),   32'd1);
      chk("scrub_waddr", 32'(mem_waddr), 32'(i));
      chk("scrub_wdata", 32'(mem_wdata), 32'h00);
      chk("scrub_ready", 32'(wr_ready),  (i == 7) ? 32'd1 : 32'd0);
      chk("scrub_wgray", 32'(wptr_gray), 32'd0);
    end
    wr_valid = 1'b0;
    tick();
    chk("idle_wen",   32'(mem_wen),   32'd0);
    chk("idle_waddr", 32'(mem_waddr), 32'd7);
    chk("idle_wgray", 32'(wptr_gray), 32'd0);

    // Fill to full against a stationary read pointer.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'hA0 + 8'(i);
      tick();
      chk("fill_wen",   32'(mem_wen),     32'd1);
      chk("fill_waddr", 32'(mem_waddr),   32'(i));
      chk("fill_wdata", 32'(mem_wdata),   32'hA0 + 32'(i));
      chk("fill_af",    32'(almost_full), (i >= 5) ? 32'd1 : 32'd0);
      chk("fill_full",  32'(full),        (i == 7) ? 32'd1 : 32'd0);
      chk("fill_ready", 32'(wr_ready),    (i == 7) ? 32'd0 : 32'd1);
    end
    chk("fill_wgray", 32'(wptr_gray), 32'b1100);

    // Stall while full.
    wr_data = 8'hB0;
    tick();
    chk("stall_wen",   32'(mem_wen),   32'd0);
    chk("stall_waddr", 32'(mem_waddr), 32'd7);
    chk("stall_wdata", 32'(mem_wdata), 32'hA7);
    chk("stall_wgray", 32'(wptr_gray), 32'b1100);
    chk("stall_full",  32'(full),      32'd1);

    // One read frees a slot, one write refills it.
    rptr_gray_sync = 4'b0001;
    tick();
    chk("free_full",  32'(full),     32'd0);
    chk("free_wen",   32'(mem_wen),  32'd0);
    chk("free_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("refill_wen",   32'(mem_wen),     32'd1);
    chk("refill_waddr", 32'(mem_waddr),   32'd0);
    chk("refill_wdata", 32'(mem_wdata),   32'hB0);
    chk("refill_full",  32'(full),        32'd1);
    chk("refill_af",    32'(almost_full), 32'd1);
    chk("refill_wgray", 32'(wptr_gray),   32'b1101);

    // Reset drops occupancy, then rescrub.
    wr_valid = 1'b0;
    rst = 1'b1;
    rptr_gray_sync = 4'b0000;
    tick();
    chk_reset("rst2");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("scrub2_waddr", 32'(mem_waddr), 32'(i));
    end
    chk("scrub2_ready", 32'(wr_ready), 32'd1);

    // 16 writes with the read pointer trailing by one: never full, pointer wraps.
    exp_bin = 4'd0;
    for (int i = 0; i < 16; i++) begin
      rptr_gray_sync = b2g(exp_bin);
      wr_valid = 1'b1;
      wr_data = 8'h10 + 8'(i);
      tick();
      chk("track_wen",   32'(mem_wen),     32'd1);
      chk("track_waddr", 32'(mem_waddr),   32'(i % 8));
      chk("track_wdata", 32'(mem_wdata),   32'h10 + 32'(i));
      chk("track_full",  32'(full),        32'd0);
      chk("track_af",    32'(almost_full), 32'd0);
      exp_bin = exp_bin + 4'd1;
    end
    wr_valid = 1'b0;
    chk("track_wgray", 32'(wptr_gray), 32'd0);

    // Five writes, then a one-cycle reset pulse mid-operation.
    rptr_gray_sync = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
      chk("pre_waddr", 32'(mem_waddr), 32'(i));
      chk("pre_wdata", 32'(mem_wdata), 32'hC0 + 32'(i));
    end
    chk("pre_wgray", 32'(wptr_gray), 32'b0111);
    rst = 1'b1;
    tick();
    chk_reset("rst3");
    rst = 1'b0;
    tick();
    chk("restart_wen",   32'(mem_wen),   32'd1);
    chk("restart_waddr", 32'(mem_waddr), 32'd0);
    chk("restart_wdata", 32'(mem_wdata), 32'h00);
    chk("restart_wgray", 32'(wptr_gray), 32'd0);
    chk("restart_ready", 32'(wr_ready),  32'd0);
    wr_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
